ghost_mover: RTL and testbench

GHOST_MOVER -- requirements
Module: ghost_mover

---
 rtl/ghost_mover_if.sv | 27 ++
 rtl/ghost_mover.sv | 138 +++++++++++++
 tb/tb_ghost_mover.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ghost_mover_if.sv
// Signal bundle between the ghost AI/maze map (master) and the ghost mover (slave).
interface ghost_mover_if;
  logic       move_tick;
  logic       respawn;
  logic [1:0] dx;
  logic [1:0] dy;
  logic       map_wall;
  logic       map_rd_en;
  logic [8:0] map_rd_x;
  logic [8:0] map_rd_y;
  logic [8:0] ghostx;
  logic [8:0] ghosty;
  logic       busy;
  logic       moved;
  logic       stalled;
  logic [2:0] state_dbg;

  modport master (
    output move_tick, respawn, dx, dy, map_wall,
    input  map_rd_en, map_rd_x, map_rd_y, ghostx, ghosty, busy, moved, stalled, state_dbg
  );

  modport slave (
    input  move_tick, respawn, dx, dy, map_wall,
    output map_rd_en, map_rd_x, map_rd_y, ghostx, ghosty, busy, moved, stalled, state_dbg
  );
endinterface

// File: rtl/ghost_mover.sv
// Steps a ghost one maze cell per tick, x before y, checking each candidate
// cell against the wall map through a fixed-latency read port.
module ghost_mover #(
  parameter int MAP_SIZE = 21,
  parameter int START_X  = 10,
  parameter int START_Y  = 9
) (
  input  logic         clock_in,
  input  logic         reset,
  ghost_mover_if.slave bus
);
  // Handshake: move_tick is a one-cycle request taken only while busy is low
  // (dropped otherwise, never queued); map_rd_en is a one-cycle read strobe and
  // map_wall is valid for that address in the following cycle, no back-pressure.
  typedef enum logic [2:0] {IDLE, RD_X, EV_X, RD_Y, EV_Y} state_t;

  localparam logic [8:0] MAX_C = 9'(MAP_SIZE - 1);
  localparam logic [8:0] ST_X  = 9'(START_X);
  localparam logic [8:0] ST_Y  = 9'(START_Y);

  state_t     state;
  logic [1:0] lat_dx, lat_dy;
  logic [8:0] pos_x, pos_y, rd_x, rd_y;
  logic       rd_en, busy_r, moved_r, stalled_r;

  // Bounds are tested on the current cell so a decrement from 0 never issues a read.
  function automatic logic axis_ok(input logic [1:0] dir, input logic [8:0] pos);
    case (dir)
      2'b01:   axis_ok = (pos < MAX_C);
      2'b10:   axis_ok = (pos != 9'd0);
      default: axis_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [8:0] cand(input logic [1:0] dir, input logic [8:0] pos);
    cand = (dir == 2'b01) ? pos + 9'd1 : pos - 9'd1;
  endfunction

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pos_x     <= ST_X;
      pos_y     <= ST_Y;
      lat_dx    <= 2'b00;
      lat_dy    <= 2'b00;
      rd_en     <= 1'b0;
      rd_x      <= 9'd0;
      rd_y      <= 9'd0;
      busy_r    <= 1'b0;
      moved_r   <= 1'b0;
      stalled_r <= 1'b0;
    end else begin
      moved_r   <= 1'b0;
      stalled_r <= 1'b0;
      if (bus.respawn) begin
        state  <= IDLE;
        pos_x  <= ST_X;
        pos_y  <= ST_Y;
        rd_en  <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.move_tick) begin
              lat_dx <= bus.dx;
              lat_dy <= bus.dy;
              if (axis_ok(bus.dx, pos_x)) begin
                state  <= RD_X;
                busy_r <= 1'b1;
                rd_en  <= 1'b1;
                rd_x   <= cand(bus.dx, pos_x);
                rd_y   <= pos_y;
              end else if (axis_ok(bus.dy, pos_y)) begin
                state  <= RD_Y;
                busy_r <= 1'b1;
                rd_en  <= 1'b1;
                rd_x   <= pos_x;
                rd_y   <= cand(bus.dy, pos_y);
              end else begin
                stalled_r <= 1'b1;
              end
            end
          end
          RD_X: begin
            state <= EV_X;
            rd_en <= 1'b0;
          end
          EV_X: begin
            if (!bus.map_wall) begin
              pos_x   <= rd_x;
              moved_r <= 1'b1;
              state   <= IDLE;
              busy_r  <= 1'b0;
            end else if (axis_ok(lat_dy, pos_y)) begin
              state <= RD_Y;
              rd_en <= 1'b1;
              rd_x  <= pos_x;
              rd_y  <= cand(lat_dy, pos_y);
            end else begin
              stalled_r <= 1'b1;
              state     <= IDLE;
              busy_r    <= 1'b0;
            end
          end
          RD_Y: begin
            state <= EV_Y;
            rd_en <= 1'b0;
          end
          EV_Y: begin
            if (!bus.map_wall) begin
              pos_y   <= rd_y;
              moved_r <= 1'b1;
            end else begin
              stalled_r <= 1'b1;
            end
            state  <= IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
            rd_en  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.map_rd_en = rd_en;
  assign bus.map_rd_x  = rd_x;
  assign bus.map_rd_y  = rd_y;
  assign bus.ghostx    = pos_x;
  assign bus.ghosty    = pos_y;
  assign bus.busy      = busy_r;
  assign bus.moved     = moved_r;
  assign bus.stalled   = stalled_r;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: default instance plus a START_X=0 instance
// for the lower-edge stall case.
module tb_ghost_mover;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_X = 3'd1;
  localparam logic [2:0] S_EV_X = 3'd2;
  localparam logic [2:0] S_RD_Y = 3'd3;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ghost_mover_if bus_a ();
  ghost_mover_if bus_b ();

  ghost_mover #(.MAP_SIZE(21), .START_X(10), .START_Y(9)) dut_a (
    .clock_in(clock_in), .reset(reset), .bus(bus_a.slave));
  ghost_mover #(.MAP_SIZE(21), .START_X(0), .START_Y(9)) dut_b (
    .clock_in(clock_in), .reset(reset), .bus(bus_b.slave));

  always #5 clock_in = ~clock_in;

  // Wall map with one-cycle read latency; the only wall is cell (9,9).
  always @(posedge clock_in)
    bus_a.map_wall <= bus_a.map_rd_en && (bus_a.map_rd_x == 9'd9) && (bus_a.map_rd_y == 9'd9);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock_in);
  endtask

  // Presents a tick in cycle 0 and returns at the sample point of cycle 1.
  task automatic tick(input logic [1:0] dxv, input logic [1:0] dyv);
    bus_a.move_tick = 1'b1;
    bus_a.dx = dxv;
    bus_a.dy = dyv;
    cyc();
    bus_a.move_tick = 1'b0;
  endtask

  task automatic respawn_a();
    bus_a.respawn = 1'b1;
    cyc();
    bus_a.respawn = 1'b0;
  endtask

  initial begin
    bus_a.move_tick = 0; bus_a.respawn = 0; bus_a.dx = 0; bus_a.dy = 0; bus_a.map_wall = 0;
    bus_b.move_tick = 0; bus_b.respawn = 0; bus_b.dx = 0; bus_b.dy = 0; bus_b.map_wall = 0;
    cyc(); cyc();
    check("rst_x", bus_a.ghostx, 10);
    check("rst_y", bus_a.ghosty, 9);
    check("rst_busy", bus_a.busy, 0);
    check("rst_rd_en", bus_a.map_rd_en, 0);
    check("rst_rd_x", bus_a.map_rd_x, 0);
    check("rst_pulses", {bus_a.moved, bus_a.stalled}, 0);
    check("rst_state", bus_a.state_dbg, S_IDLE);
    reset = 1'b0;

    // x move, with dx changed after the tick to prove it was latched
    tick(2'b01, 2'b00);
    bus_a.dx = 2'b10;
    check("x_rd_en", bus_a.map_rd_en, 1);
    check("x_rd_xy", {bus_a.map_rd_x, bus_a.map_rd_y}, {9'd11, 9'd9});
    check("x_busy", bus_a.busy, 1);
    cyc();
    check("x_ev_state", bus_a.state_dbg, S_EV_X);
    check("x_ev_rd_en", bus_a.map_rd_en, 0);
    cyc();
    check("x_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd11, 9'd9});
    check("x_moved", bus_a.moved, 1);
    check("x_busy_low", bus_a.busy, 0);
    cyc();
    check("x_moved_once", bus_a.moved, 0);
    respawn_a();
    check("resp_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd10, 9'd9});

    // x blocked by wall at (9,9), falls back to y
    tick(2'b10, 2'b01);
    check("fb_rd1", {bus_a.map_rd_en, bus_a.map_rd_x, bus_a.map_rd_y}, {1'b1, 9'd9, 9'd9});
    cyc(); cyc();
    check("fb_state", bus_a.state_dbg, S_RD_Y);
    check("fb_rd2", {bus_a.map_rd_en, bus_a.map_rd_x, bus_a.map_rd_y}, {1'b1, 9'd10, 9'd10});
    cyc();
    check("fb_no_move_c4", bus_a.moved, 0);
    cyc();
    check("fb_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd10, 9'd10});
    check("fb_moved", bus_a.moved, 1);
    respawn_a();

    // tick during EV_X is dropped; respawn in RD_Y discards the y move
    tick(2'b01, 2'b00);
    cyc();
    bus_a.move_tick = 1'b1; bus_a.dx = 2'b00; bus_a.dy = 2'b01;
    cyc();
    bus_a.move_tick = 1'b0;
    check("ign_moved", bus_a.moved, 1);
    cyc();
    check("ign_idle", {bus_a.busy, bus_a.state_dbg}, {1'b0, S_IDLE});
    check("ign_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd11, 9'd9});
    tick(2'b00, 2'b01);
    check("ry_state", bus_a.state_dbg, S_RD_Y);
    bus_a.respawn = 1'b1;
    cyc();
    bus_a.respawn = 1'b0;
    check("ry_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd10, 9'd9});
    check("ry_idle", {bus_a.busy, bus_a.state_dbg, bus_a.moved, bus_a.stalled}, {1'b0, S_IDLE, 2'b00});
    cyc();
    check("ry_no_late_move", {bus_a.moved, bus_a.ghosty}, {1'b0, 9'd9});

    // asynchronous reset during EV_X, then a tick on the first edge after release
    tick(2'b01, 2'b00);
    cyc();
    check("ar_in_ev", bus_a.state_dbg, S_EV_X);
    #2 reset = 1'b1;
    #1 check("ar_pos", {bus_a.ghostx, bus_a.ghosty}, {9'd10, 9'd9});
    check("ar_ctl", {bus_a.busy, bus_a.state_dbg, bus_a.map_rd_en, bus_a.moved}, 0);
    #1 reset = 1'b0;
    bus_a.move_tick = 1'b1; bus_a.dx = 2'b01; bus_a.dy = 2'b00;
    cyc();
    bus_a.move_tick = 1'b0;
    check("ar_first_tick", bus_a.state_dbg, S_RD_X);
    check("ar_no_moved", {bus_a.moved, bus_a.ghostx}, {1'b0, 9'd10});
    cyc(); cyc();
    check("ar_then_move", bus_a.ghostx, 11);

    // walk to the right edge
    for (int i = 0; i < 9; i++) begin
      tick(2'b01, 2'b00);
      cyc(); cyc();
    end
    check("edge_x", {bus_a.ghostx, bus_a.ghosty}, {9'd20, 9'd9});

    // at x=20 the +x candidate is off-map: no x read, straight to y
    tick(2'b01, 2'b10);
    check("edge_state", bus_a.state_dbg, S_RD_Y);
    check("edge_rd", {bus_a.map_rd_en, bus_a.map_rd_x, bus_a.map_rd_y}, {1'b1, 9'd20, 9'd8});
    cyc(); cyc();
    check("edge_pos", {bus_a.ghostx, bus_a.ghosty, bus_a.moved}, {9'd20, 9'd8, 1'b1});
    tick(2'b01, 2'b00);
    check("edge_stall", {bus_a.stalled, bus_a.map_rd_en, bus_a.busy}, {1'b1, 1'b0, 1'b0});
    cyc();
    check("edge_stall_once", {bus_a.stalled, bus_a.ghostx}, {1'b0, 9'd20});
    tick(2'b11, 2'b11);
    check("none_stall", {bus_a.stalled, bus_a.map_rd_en, bus_a.ghostx, bus_a.ghosty}, {1'b1, 1'b0, 9'd20, 9'd8});

    // START_X=0 instance: -x from x=0 stalls with no read
    bus_b.respawn = 1'b1;
    cyc();
    bus_b.respawn = 1'b0;
    check("b_resp", {bus_b.ghostx, bus_b.ghosty}, {9'd0, 9'd9});
    bus_b.move_tick = 1'b1; bus_b.dx = 2'b10; bus_b.dy = 2'b00;
    cyc();
    bus_b.move_tick = 1'b0;
    check("b_stall", {bus_b.stalled, bus_b.map_rd_en, bus_b.busy}, {1'b1, 1'b0, 1'b0});
    cyc();
    check("b_after", {bus_b.stalled, bus_b.ghostx, bus_b.ghosty}, {1'b0, 9'd0, 9'd9});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
